// File: rtl/dm_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
//   dm_size_e   : request size codes (11 behaves as a word access)
//   dm_state_e  : controller FSM states
//   DM_RD_LATENCY : DM read latency in cycles. The RD -> CAP sequence
//                   relies on this being 1.
//   size_is_word / access_misaligned : request decode helpers
package dm_access_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_WORD     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } dm_size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RESP
  } dm_state_e;

  localparam int unsigned DM_RD_LATENCY = 1;

  function automatic logic size_is_word(input logic [1:0] size);
    return size[1];
  endfunction

  // A half must sit on an even byte; a word must sit on lane 0.
  function automatic logic access_misaligned(input logic [1:0] size,
                                             input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    if (size_is_word(size)) begin
      mis = (lane != 2'b00);
    end else if (size == SZ_HALF) begin
      mis = lane[0];
    end
    return mis;
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Combinational byte-lane logic for dm_access_ctrl (little-endian lanes).
//   size_i    : access size
//   sign_i    : 1 = sign-extend loads, 0 = zero-extend
//   lane_i    : byte address bits [1:0]
//   rdata_i   : word read from DM
//   wdata_i   : right-justified store data
//   ld_data_o : selected lane, extended to WIDTH
//   st_word_o : rdata_i with the store lane replaced (whole wdata_i for words)
// A half uses only lane_i[1]; a word ignores lane_i.
module dm_lane_unit
  import dm_access_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  dm_size_e         size_i,
  input  logic             sign_i,
  input  logic [1:0]       lane_i,
  input  logic [WIDTH-1:0] rdata_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] ld_data_o,
  output logic [WIDTH-1:0] st_word_o
);

  logic [4:0]       byte_sh;
  logic [4:0]       half_sh;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [WIDTH-1:0] byte_mask;
  logic [WIDTH-1:0] half_mask;

  always_comb begin
    byte_sh   = {lane_i, 3'b000};
    half_sh   = {lane_i[1], 4'b0000};
    byte_v    = 8'(rdata_i >> byte_sh);
    half_v    = 16'(rdata_i >> half_sh);
    byte_mask = WIDTH'(8'hFF) << byte_sh;
    half_mask = WIDTH'(16'hFFFF) << half_sh;
    ld_data_o = rdata_i;
    st_word_o = wdata_i;
    unique case (size_i)
      SZ_BYTE: begin
        ld_data_o = sign_i ? {{(WIDTH-8){byte_v[7]}}, byte_v}
                           : {{(WIDTH-8){1'b0}}, byte_v};
        st_word_o = (rdata_i & ~byte_mask)
                  | ((WIDTH'(wdata_i[7:0]) << byte_sh) & byte_mask);
      end
      SZ_HALF: begin
        ld_data_o = sign_i ? {{(WIDTH-16){half_v[15]}}, half_v}
                           : {{(WIDTH-16){1'b0}}, half_v};
        st_word_o = (rdata_i & ~half_mask)
                  | ((WIDTH'(wdata_i[15:0]) << half_sh) & half_mask);
      end
      default: begin
        ld_data_o = rdata_i;
        st_word_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Load/store initiator for the datapath data memory (DM).
// Accepts one CPU request at a time, drives the word-wide DM port, and
// returns extended load data. Sub-word stores read-modify-write the word.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake (ready only when idle)
//   req_we/size/sign/addr/wdata : request fields (byte address)
//   resp_valid            : one-cycle completion pulse
//   resp_rdata/resp_err   : result, held until the next response
//   dm_rd_en/dm_wr_en/dm_addr/dm_wdata : DM command (registered)
//   dm_rdata              : DM read data, valid the cycle after dm_rd_en
// Optional build macro DM_ALIGN_CHECK_EN: misaligned half/word requests
// complete at once with resp_err=1 and no DM access. Without it resp_err
// stays 0 and the misaligned low address bits are ignored.
module dm_access_ctrl
  import dm_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 10,
  parameter int unsigned WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_sign,
  input  logic [ADDR_SIZE+1:0] req_addr,
  input  logic [WIDTH-1:0]     req_wdata,
  output logic                 resp_valid,
  output logic [WIDTH-1:0]     resp_rdata,
  output logic                 resp_err,
  output logic                 dm_rd_en,
  output logic                 dm_wr_en,
  output logic [ADDR_SIZE-1:0] dm_addr,
  output logic [WIDTH-1:0]     dm_wdata,
  input  logic [WIDTH-1:0]     dm_rdata
);

  dm_state_e            state_q, state_d;
  logic                 we_q, we_d;
  dm_size_e             size_q, size_d;
  logic                 sign_q, sign_d;
  logic [1:0]           lane_q, lane_d;
  logic                 req_ready_q, req_ready_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]     resp_rdata_q, resp_rdata_d;
  logic                 resp_err_q, resp_err_d;
  logic                 dm_rd_en_q, dm_rd_en_d;
  logic                 dm_wr_en_q, dm_wr_en_d;
  logic [ADDR_SIZE-1:0] dm_addr_q, dm_addr_d;
  logic [WIDTH-1:0]     dm_wdata_q, dm_wdata_d;

  logic                 req_misaligned;
  logic [WIDTH-1:0]     ld_data;
  logic [WIDTH-1:0]     st_word;

`ifdef DM_ALIGN_CHECK_EN
  assign req_misaligned = access_misaligned(req_size, req_addr[1:0]);
`else
  assign req_misaligned = 1'b0;
`endif

  // dm_wdata_q carries the raw store data from acceptance until CAP, where
  // the lane unit merges it into the word just read.
  dm_lane_unit #(
    .WIDTH (WIDTH)
  ) u_lane (
    .size_i    (size_q),
    .sign_i    (sign_q),
    .lane_i    (lane_q),
    .rdata_i   (dm_rdata),
    .wdata_i   (dm_wdata_q),
    .ld_data_o (ld_data),
    .st_word_o (st_word)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    sign_d       = sign_q;
    lane_d       = lane_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    dm_addr_d    = dm_addr_q;
    dm_wdata_d   = dm_wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d       = req_we;
          size_d     = dm_size_e'(req_size);
          sign_d     = req_sign;
          lane_d     = req_addr[1:0];
          dm_addr_d  = req_addr[ADDR_SIZE+1:2];
          dm_wdata_d = req_wdata;
          if (req_misaligned) begin
            state_d      = S_RESP;
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
          end else if (req_we && size_is_word(req_size)) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        state_d = S_CAP;
      end
      S_CAP: begin
        if (we_q) begin
          dm_wdata_d = st_word;
          state_d    = S_WR;
        end else begin
          resp_rdata_d = ld_data;
          resp_err_d   = 1'b0;
          state_d      = S_RESP;
        end
      end
      S_WR: begin
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        state_d      = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered copies of what the next state implies.
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    dm_rd_en_d   = (state_d == S_RD);
    dm_wr_en_d   = (state_d == S_WR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      sign_q       <= 1'b0;
      lane_q       <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      dm_rd_en_q   <= 1'b0;
      dm_wr_en_q   <= 1'b0;
      dm_addr_q    <= '0;
      dm_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
      lane_q       <= lane_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      dm_rd_en_q   <= dm_rd_en_d;
      dm_wr_en_q   <= dm_wr_en_d;
      dm_addr_q    <= dm_addr_d;
      dm_wdata_q   <= dm_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign dm_rd_en   = dm_rd_en_q;
  assign dm_wr_en   = dm_wr_en_q;
  assign dm_addr    = dm_addr_q;
  assign dm_wdata   = dm_wdata_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_sign = 1'b0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dm_rd_en;
  logic        dm_wr_en;
  logic [9:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata = '0;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  dm_access_ctrl #(
    .ADDR_SIZE (10),
    .WIDTH     (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_sign   (req_sign),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .dm_rd_en   (dm_rd_en),
    .dm_wr_en   (dm_wr_en),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata)
  );

  // DM: 1024 words, registered read, preloaded once with a known pattern.
  function automatic logic [31:0] init_word(input int unsigned w);
    return (w * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  logic [31:0] dm_mem [0:1023];
  logic        init_done = 1'b0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int unsigned w = 0; w < 1024; w++) dm_mem[w] <= init_word(w);
      init_done <= 1'b1;
    end else begin
      if (dm_rd_en) dm_rdata <= dm_mem[dm_addr];
      if (dm_wr_en) dm_mem[dm_addr] <= dm_wdata;
    end
  end

  always @(negedge clk) begin
    if (dm_rd_en && dm_wr_en) begin
      errors++;
      $display("FAIL rd_wr_overlap: dm_rd_en=%b dm_wr_en=%b required not both", dm_rd_en, dm_wr_en);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: byte-addressed memory, accesses computed byte by byte.
  logic [7:0] ref_mem [0:4095];

  function automatic int unsigned nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic ref_misaligned(input logic [1:0] size, input logic [11:0] a);
    logic m;
    m = 1'b0;
`ifdef DM_ALIGN_CHECK_EN
    m = (int'(a) % nbytes(size)) != 0;
`endif
    return m;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sign, input logic [11:0] a);
    int unsigned n, b;
    logic [31:0] v;
    n = nbytes(size);
    b = int'(a) - (int'(a) % n);
    v = '0;
    for (int unsigned i = 0; i < n; i++) v = v | (32'(ref_mem[b + i]) << (8 * i));
    if (sign && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [11:0] a, input logic [31:0] d);
    int unsigned n, b;
    n = nbytes(size);
    b = int'(a) - (int'(a) % n);
    for (int unsigned i = 0; i < n; i++) ref_mem[b + i] = 8'((d >> (8 * i)) & 32'hFF);
  endtask

  function automatic logic [31:0] ref_word(input logic [9:0] w);
    return {ref_mem[{w, 2'b11}], ref_mem[{w, 2'b10}], ref_mem[{w, 2'b01}], ref_mem[{w, 2'b00}]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Drives one request, follows it to completion (bounded), and reports
  // what the DM port and response did relative to the accept cycle T.
  task automatic run_txn(input logic we, input logic [1:0] size, input logic sign,
                         input logic [11:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int rd_cyc, output int wr_cyc, output logic [9:0] wr_addr,
                         output logic [31:0] wr_data, output int ready_busy, output logic one_pulse);
    int k;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
    req_addr = addr; req_wdata = wdata;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0; rd_cyc = 0; wr_cyc = 0; ready_busy = 0; wr_addr = '0; wr_data = '0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) @(negedge clk);
      if (dm_rd_en && rd_cyc == 0) rd_cyc = c;
      if (dm_wr_en && wr_cyc == 0) begin wr_cyc = c; wr_addr = dm_addr; wr_data = dm_wdata; end
      if (req_ready) ready_busy++;
      if (resp_valid) begin lat = c; break; end
    end
    rdata = resp_rdata;
    err   = resp_err;
    @(negedge clk);
    one_pulse = !resp_valid && (resp_rdata === rdata) && (resp_err === err) && req_ready;
  endtask

  logic [31:0] last_rd, last_wr;

  task automatic check_txn(input string tag, input logic we, input logic [1:0] size, input logic sign,
                           input logic [11:0] addr, input logic [31:0] wdata);
    logic mis, err, one;
    logic [31:0] exp_rd, exp_wr, rd, wd;
    logic [9:0] wa;
    int lat, rc, wc, rb, exp_lat, exp_rc, exp_wc;
    mis = ref_misaligned(size, addr);
    exp_rd = '0;
    exp_wr = '0;
    if (!mis && !we) exp_rd = ref_load(size, sign, addr);
    if (!mis && we) begin
      ref_store(size, addr, wdata);
      exp_wr = ref_word(addr[11:2]);
    end
    exp_lat = mis ? 1 : (!we ? 3 : ((nbytes(size) == 4) ? 2 : 4));
    exp_rc  = (mis || (we && nbytes(size) == 4)) ? 0 : 1;
    exp_wc  = (mis || !we) ? 0 : ((nbytes(size) == 4) ? 1 : 3);
    run_txn(we, size, sign, addr, wdata, rd, err, lat, rc, wc, wa, wd, rb, one);
    last_rd = rd;
    last_wr = wd;
    chk({tag, ".rdata"}, rd, exp_rd);
    chk({tag, ".err"}, 32'(err), 32'(mis));
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rd_cycle"}, 32'(rc), 32'(exp_rc));
    chk({tag, ".wr_cycle"}, 32'(wc), 32'(exp_wc));
    chk({tag, ".ready_busy"}, 32'(rb), 32'd0);
    chk({tag, ".resp_hold"}, 32'(one), 32'd1);
    if (we && !mis) begin
      chk({tag, ".wr_addr"}, 32'(wa), 32'(addr[11:2]));
      chk({tag, ".wr_data"}, wd, exp_wr);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        chk_wr;
    logic [31:0] exp_wr;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sign,
                              input logic [11:0] addr, input logic [31:0] wdata,
                              input logic chk_rd, input logic [31:0] exp_rd,
                              input logic chk_wr, input logic [31:0] exp_wr);
    vec_t v;
    v.we = we; v.size = size; v.sign = sign; v.addr = addr; v.wdata = wdata;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.chk_wr = chk_wr; v.exp_wr = exp_wr;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [31:0] got [3];
    logic [31:0] bexp [3];
    logic [11:0] baddr [3];
    logic [31:0] mis_exp;
    int idx, pulses, accepted;
    logic acc, saw_resp;
    int mism;

    for (int unsigned w = 0; w < 1024; w++) begin
      logic [31:0] iv;
      iv = init_word(w);
      for (int unsigned b = 0; b < 4; b++) ref_mem[w * 4 + b] = 8'(iv >> (8 * b));
    end

`ifdef DM_ALIGN_CHECK_EN
    mis_exp = 32'h0000_0000;
`else
    mis_exp = 32'h8000_FF7F;
`endif
    //          we    sz     sg    addr    wdata         chk   exp_rd        chk   exp_wr
    tbl.push_back(mk(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 1'b1, 32'h0,        1'b1, 32'hDEADBEEF));
    tbl.push_back(mk(1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 2'b10, 1'b0, 12'h010, 32'h11223344, 1'b0, 32'h0,        1'b1, 32'h11223344));
    tbl.push_back(mk(1'b1, 2'b00, 1'b0, 12'h013, 32'h000000AB, 1'b1, 32'h0,        1'b1, 32'hAB223344));
    tbl.push_back(mk(1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        1'b1, 32'hAB223344, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 2'b10, 1'b0, 12'h010, 32'h8000FF7F, 1'b0, 32'h0,        1'b1, 32'h8000FF7F));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 12'h012, 32'h0,        1'b1, 32'h00000000, 1'b0, 32'h0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b1, 12'h011, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b0, 32'h0));
    tbl.push_back(mk(1'b0, 2'b01, 1'b1, 12'h012, 32'h0,        1'b1, 32'hFFFF8000, 1'b0, 32'h0));
    tbl.push_back(mk(1'b0, 2'b01, 1'b0, 12'h012, 32'h0,        1'b1, 32'h00008000, 1'b0, 32'h0));
    tbl.push_back(mk(1'b0, 2'b00, 1'b0, 12'h010, 32'h0,        1'b1, 32'h0000007F, 1'b0, 32'h0));
    tbl.push_back(mk(1'b0, 2'b11, 1'b1, 12'h010, 32'h0,        1'b1, 32'h8000FF7F, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 2'b10, 1'b0, 12'h014, 32'h00000000, 1'b0, 32'h0,        1'b1, 32'h00000000));
    tbl.push_back(mk(1'b1, 2'b01, 1'b0, 12'h016, 32'h1234ABCD, 1'b0, 32'h0,        1'b1, 32'hABCD0000));
    tbl.push_back(mk(1'b1, 2'b10, 1'b0, 12'hFFC, 32'h55AA66BB, 1'b0, 32'h0,        1'b1, 32'h55AA66BB));
    tbl.push_back(mk(1'b0, 2'b01, 1'b0, 12'hFFE, 32'h0,        1'b1, 32'h000055AA, 1'b0, 32'h0));
    tbl.push_back(mk(1'b0, 2'b10, 1'b0, 12'h013, 32'h0,        1'b1, mis_exp,      1'b0, 32'h0));

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_err", 32'(resp_err), 32'd0);
    chk("rst.resp_rdata", resp_rdata, 32'd0);
    chk("rst.dm_rd_en", 32'(dm_rd_en), 32'd0);
    chk("rst.dm_wr_en", 32'(dm_wr_en), 32'd0);
    chk("rst.dm_addr", 32'(dm_addr), 32'd0);
    chk("rst.dm_wdata", dm_wdata, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table
    for (int i = 0; i < tbl.size(); i++) begin
      check_txn($sformatf("tbl%0d", i), tbl[i].we, tbl[i].size, tbl[i].sign, tbl[i].addr, tbl[i].wdata);
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d.const_rdata", i), last_rd, tbl[i].exp_rd);
      if (tbl[i].chk_wr) chk($sformatf("tbl%0d.const_wdata", i), last_wr, tbl[i].exp_wr);
    end

    // Reset during CAP of a sub-word store: the store must be lost.
    check_txn("pre_rst", 1'b1, 2'b10, 1'b0, 12'h020, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_sign = 1'b0;
    req_addr = 12'h020; req_wdata = 32'h00001234;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rmw_rst.rd_phase", 32'(dm_rd_en), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rmw_rst.rd_en", 32'(dm_rd_en), 32'd0);
    chk("rmw_rst.wr_en", 32'(dm_wr_en), 32'd0);
    chk("rmw_rst.resp_valid", 32'(resp_valid), 32'd0);
    saw_resp = 1'b0;
    repeat (2) begin @(negedge clk); if (resp_valid || dm_wr_en) saw_resp = 1'b1; end
    rst_n = 1'b1;
    repeat (5) begin @(negedge clk); if (resp_valid || dm_wr_en) saw_resp = 1'b1; end
    chk("rmw_rst.no_resp", 32'(saw_resp), 32'd0);
    chk("rmw_rst.ready", 32'(req_ready), 32'd1);
    chk("rmw_rst.mem8", dm_mem[8], 32'hCAFEF00D);

    // Reset during RD of a load: read enable must drop without a clock.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 12'h020;
    @(negedge clk);
    req_valid = 1'b0;
    chk("ld_rst.rd_phase", 32'(dm_rd_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ld_rst.rd_en", 32'(dm_rd_en), 32'd0);
    chk("ld_rst.ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Back-to-back loads with req_valid held high.
    baddr[0] = 12'h010; baddr[1] = 12'h020; baddr[2] = 12'h016;
    for (int i = 0; i < 3; i++) bexp[i] = ref_load(2'b10, 1'b0, baddr[i]);
    for (int i = 0; i < 3; i++) got[i] = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_sign = 1'b0; req_addr = baddr[0];
    idx = 0; pulses = 0; accepted = 0;
    for (int c = 0; c < 40; c++) begin
      acc = req_ready && req_valid;
      if (acc) accepted++;
      @(negedge clk);
      if (resp_valid) begin
        if (pulses < 3) got[pulses] = resp_rdata;
        pulses++;
      end
      if (acc) begin
        idx++;
        if (idx < 3) req_addr = baddr[idx];
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("b2b.accepts", 32'(accepted), 32'd3);
    chk("b2b.pulses", 32'(pulses), 32'd3);
    for (int i = 0; i < 3; i++) chk($sformatf("b2b.data%0d", i), got[i], bexp[i]);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 250; n++) begin
      logic r_we, r_sign;
      logic [1:0] r_size;
      logic [11:0] r_addr;
      r_we   = 1'($urandom_range(0, 1));
      r_sign = 1'($urandom_range(0, 1));
      r_size = 2'($urandom_range(0, 3));
      r_addr = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 63)) : 12'($urandom_range(0, 4095));
      check_txn($sformatf("rnd%0d", n), r_we, r_size, r_sign, r_addr, $urandom);
    end

    repeat (2) @(negedge clk);
    mism = 0;
    for (int unsigned w = 0; w < 1024; w++) if (dm_mem[w] !== ref_word(10'(w))) mism++;
    chk("mem_image", 32'(mism), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
